// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with an
// IDLE/RUN/DONE controller and registered busy/done/sum/cout outputs.

module half_adder (
   input  logic x_i,
   input  logic y_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = x_i ^ y_i;
   assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, carry_d, cout_q, busy_q, done_q;
   logic             psum, pcarry, sbit, scarry, last_bit;

   half_adder u_ha_ab (.x_i(a_q[0]), .y_i(b_q[0]),   .s_o(psum), .c_o(pcarry));
   half_adder u_ha_c  (.x_i(psum),   .y_i(carry_q),  .s_o(sbit), .c_o(scarry));

   assign carry_d  = pcarry | scarry;
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
   always_comb begin
      res_d            = res_q >> 1;
      res_d[WIDTH-1]   = sbit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  res_q   <= '0;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               res_q   <= res_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, scoreboard of
// expected {cout,sum} pushed at start and popped on done.

module tb_serial_add_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset8, start8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       reset1, start1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int dcnt8  = 0;
   int dcnt1  = 0;

   logic [8:0] q8[$];
   logic [1:0] q1[$];

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done8) dcnt8 <= dcnt8 + 1;
      if (done1) dcnt1 <= dcnt1 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one WIDTH=8 op and returns in the DONE cycle (or after a timeout).
   task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit noise,
                         output int lat, output int bcyc);
      logic [8:0] exp;
      logic [7:0] prev_sum;
      bit         held;
      prev_sum = sum8;
      held     = 1'b1;
      a8 = av; b8 = bv; start8 = 1'b1;
      q8.push_back({1'b0, av} + {1'b0, bv});
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      lat = 0; bcyc = 0;
      while (!done8 && lat < 40) begin
         if (busy8) bcyc++;
         if (sum8 !== prev_sum) held = 1'b0;
         if (noise) begin
            start8 = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
         tick();
         lat++;
      end
      checks++;
      if (lat >= 40) begin
         errors++;
         $display("FAIL op_timeout a=%h b=%h: no done within %0d cycles", av, bv, lat);
         if (q8.size() > 0) void'(q8.pop_front());
      end else begin
         exp = q8.pop_front();
         if ({cout8, sum8} !== exp) begin
            errors++;
            $display("FAIL op_result a=%h b=%h: got cout=%b sum=%h, want cout=%b sum=%h",
                     av, bv, cout8, sum8, exp[8], exp[7:0]);
         end
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL sum_hold_in_run a=%h b=%h: sum changed during RUN, want %h held", av, bv, prev_sum);
      end
      checks++;
      if (busy8 !== 1'b0) begin
         errors++;
         $display("FAIL busy_in_done: got %b want 0", busy8);
      end
   endtask

   task automatic test_reset();
      start8 = 0; a8 = 0; b8 = 0; reset8 = 1;
      start1 = 0; a1 = 0; b1 = 0; reset1 = 1;
      tick(); tick(); tick();
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
      end
      reset8 = 0; reset1 = 0;
      tick(); tick(); tick(); tick(); tick();
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h0 || dcnt8 !== 0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b done=%b cout=%b sum=%h pulses=%0d want 0",
                  busy8, done8, cout8, sum8, dcnt8);
      end
   endtask

   task automatic test_add();
      logic [7:0] ta[3] = '{8'hFF, 8'hA5, 8'h80};
      logic [7:0] tb[3] = '{8'h01, 8'h5A, 8'h80};
      int lat, bcyc;
      for (int i = 0; i < 3; i++) begin
         do_op8(ta[i], tb[i], 1'b0, lat, bcyc);
         checks++;
         if (lat !== 8 || bcyc !== 8) begin
            errors++;
            $display("FAIL add_timing %0d: got done after %0d edges busy %0d cycles, want 8/8", i, lat, bcyc);
         end
         tick();
         checks++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL add_back_idle %0d: got done=%b busy=%b want 0/0", i, done8, busy8);
         end
      end
   endtask

   task automatic test_ignore();
      int lat, bcyc, d0, extra_busy;
      d0 = dcnt8;
      do_op8(8'h12, 8'h34, 1'b1, lat, bcyc);
      start8 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF;
      tick();
      start8 = 1'b0;
      extra_busy = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy8) extra_busy++;
         tick();
      end
      checks++;
      if (dcnt8 - d0 !== 1 || extra_busy !== 0 || lat !== 8) begin
         errors++;
         $display("FAIL ignore_start: got pulses=%0d extra_busy=%0d lat=%0d want 1/0/8", dcnt8 - d0, extra_busy, lat);
      end
      checks++;
      if ({cout8, sum8} !== 9'h046) begin
         errors++;
         $display("FAIL ignore_result_hold: got cout=%b sum=%h want 0/46", cout8, sum8);
      end
   endtask

   task automatic test_reset_abort();
      int lat, bcyc, d0;
      a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
      q8.push_back(9'h010);
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      reset8 = 1'b1;
      #1;
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h0) begin
         errors++;
         $display("FAIL abort_outputs: got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
      end
      void'(q8.pop_back());
      tick(); tick();
      reset8 = 1'b0;
      d0 = dcnt8;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (dcnt8 !== d0 || sum8 !== 8'h00) begin
         errors++;
         $display("FAIL abort_no_done: got pulses=%0d sum=%h want 0/00", dcnt8 - d0, sum8);
      end
      do_op8(8'h0F, 8'h01, 1'b0, lat, bcyc);
      checks++;
      if (lat !== 8) begin
         errors++;
         $display("FAIL after_abort_latency: got %0d want 8", lat);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat, bcyc, t1, t2;
      do_op8(8'h01, 8'h01, 1'b0, lat, bcyc);
      t1 = cyc;
      tick();
      do_op8(8'hFE, 8'h03, 1'b0, lat, bcyc);
      t2 = cyc;
      checks++;
      if (t2 - t1 !== 10) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles between done pulses want 10", t2 - t1);
      end
      tick();
   endtask

   task automatic test_width1();
      logic [1:0] exp;
      for (int i = 0; i < 4; i++) begin
         a1 = 1'(i >> 1);
         b1 = 1'(i);
         start1 = 1'b1;
         q1.push_back({1'b0, a1} + {1'b0, b1});
         tick();
         start1 = 1'b0;
         checks++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_run %0d: got busy=%b done=%b want 1/0", i, busy1, done1);
         end
         tick();
         checks++;
         if (busy1 !== 1'b0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_done %0d: got busy=%b done=%b want 0/1", i, busy1, done1);
         end
         exp = q1.pop_front();
         checks++;
         if ({cout1, sum1} !== exp) begin
            errors++;
            $display("FAIL w1_result %0d: got %b%b want %b", i, cout1, sum1, exp);
         end
         tick();
         checks++;
         if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_idle %0d: got busy=%b done=%b want 0/0", i, busy1, done1);
         end
      end
      checks++;
      if (dcnt1 !== 4) begin
         errors++;
         $display("FAIL w1_pulses: got %0d want 4", dcnt1);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ignore();
      test_reset_abort();
      test_back_to_back();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new addition; sampled on the rising clk edge.
REQ-005 SHALL have port a, input, WIDTH bits: first operand, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: second operand, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed result.
REQ-009 SHALL have port sum, output, WIDTH bits: result of the last completed addition.
REQ-010 SHALL have port cout, output, 1 bit: carry-out of the last completed addition.

Function
REQ-011 SHALL compute a + b bit-serially, one bit per clk cycle, LSB first.
REQ-012 SHALL form each bit from exactly two half_adder instances plus an OR gate that merges their carries:
  - half_adder #1 adds a-bit and b-bit.
  - half_adder #2 adds that partial sum and the carry flip-flop.
  - sum bit = s of half_adder #2.
  - next carry = c of #1 OR c of #2.
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, SHALL, on the clk edge (E0):
  - latch a and b into internal shift registers;
  - clear the carry flip-flop;
  - clear the bit counter;
  - enter RUN.
REQ-015 In RUN, SHALL perform one bit step per edge:
  - shift the operand registers right by one;
  - shift the new sum bit into the MSB of an internal result shift register;
  - update the carry flip-flop;
  - increment the counter.
REQ-016 SHALL leave RUN on the edge that completes bit WIDTH-1 (edge E0+WIDTH); on that edge it SHALL copy the result shift register to sum and the carry to cout, then enter DONE.
REQ-017 SHALL hold done=1 for exactly the one cycle spent in DONE (the cycle after edge E0+WIDTH), then return to IDLE unconditionally on the next edge.
REQ-018 SHALL drive busy=1 exactly while in RUN (WIDTH cycles), and busy=0 in IDLE and DONE.
REQ-019 SHALL change sum and cout only on the edge entering DONE; they SHALL hold their values through RUN and IDLE until the next completion.
REQ-020 SHALL ignore start in RUN and DONE: no restart, no operand re-latch, no effect on the next operation.
REQ-021 SHALL accept start in the IDLE cycle immediately after DONE; the maximum issue rate is therefore one operation per WIDTH+2 cycles.
REQ-022 SHALL ignore changes on a and b after E0.
REQ-023 SHALL size the counter as ceil(log2(WIDTH+1)) bits; with WIDTH=1, RUN SHALL last exactly one cycle.
REQ-024 SHALL make cout the true carry out of bit WIDTH-1, so {cout,sum} = a+b exactly, with no overflow wrap.

Reset
REQ-025 When reset=1, SHALL immediately, independent of clk:
  - force state IDLE;
  - set busy=0, done=0, sum=0, cout=0;
  - clear the carry, counter and shift registers.
REQ-026 Reset asserted during RUN SHALL abort the operation: no done pulse, no sum update; the first start after reset deasserts SHALL be accepted normally.
REQ-027 SHALL accept start no earlier than the first clk edge at which reset=0.

Verification
REQ-028 Reset then idle (WIDTH=8) -> sum=0x00, cout=0, busy=0, done=0; done never pulses without start.
REQ-029 Additions (WIDTH=8), each with start=1 at E0:
  - 0xFF+0x01 -> busy high for 8 cycles, done high in cycle 9 after E0, sum=0x00, cout=1;
  - 0xA5+0x5A -> sum=0xFF, cout=0;
  - 0x80+0x80 -> sum=0x00, cout=1.
REQ-030 Start pulses and operand changes during RUN and DONE of 0x12+0x34 -> result sum=0x46, cout=0; exactly one done pulse; no extra operation.
REQ-031 Reset asserted 3 cycles into RUN of 0x0F+0x01 -> busy/done=0 at once, sum remains 0x00, no done; a following 0x0F+0x01 yields sum=0x10, cout=0.
REQ-032 Back-to-back start asserted in the IDLE cycle after DONE (0x01+0x01, then 0xFE+0x03) -> sums 0x02 then 0x01 with cout 0 then 1; done pulses 10 cycles apart.
REQ-033 WIDTH=1, all four a/b combinations -> {cout,sum} = 00, 01, 01, 10; busy exactly 1 cycle; done in the following cycle.
